// File: rtl/music_ctrl_if.sv
// Button, ROM and tone-generator signals of the music controller.
// The master side drives button/ROM inputs; the slave side is the controller.
interface music_ctrl_if;
    logic       music_en;
    logic       loop_en;
    logic [7:0] rom_data;
    logic [5:0] rom_addr;
    logic [4:0] tone_code;
    logic       playing;
    logic       paused;
    logic       short_evt;
    logic       long_evt;

    modport master (
        output music_en, loop_en, rom_data,
        input  rom_addr, tone_code, playing, paused, short_evt, long_evt
    );

    modport slave (
        input  music_en, loop_en, rom_data,
        output rom_addr, tone_code, playing, paused, short_evt, long_evt
    );
endinterface

// File: rtl/music_ctrl.sv
// Note-ROM sequencer driven by one debounced button: a short press plays/pauses/resumes,
// and a long press stops and rewinds.
module music_ctrl #(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned LONG_CYCLES = 2500000,
    parameter int unsigned BEAT_CYCLES = 6250000
) (
    input  logic        clk,
    input  logic        rst,
    music_ctrl_if.slave ctrl
);
    localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
    localparam int unsigned PRESS_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned HOLD_W  = $clog2(7 * BEAT_CYCLES + 1);
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned PITCH_W = 5;
    localparam int unsigned LEN_W   = 3;
    localparam logic [PITCH_W-1:0] END_MARK = 5'h1F;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [PITCH_W-1:0] pitch;
    } note_t;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, PAUSE} state_t;

    note_t note;
    assign note = note_t'(ctrl.rom_data);

    // ---------------- button path ----------------
    logic               sync1_q, sync2_q;
    logic               db_q, db_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [DB_W-1:0]    arm_cnt_q, arm_cnt_d;
    logic               armed_q, armed_d;
    logic [PRESS_W-1:0] press_cnt_q, press_cnt_d;
    logic               short_q, short_d;
    logic               long_q, long_d;

    // Debounced level follows the synchronized level only after a full stable run.
    always_comb begin : debounce_c
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) db_d = sync2_q;
            else                                  db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Presses are recognised only once the button has been seen stably released,
    // so a button held through reset cannot produce an event.
    always_comb begin : arm_c
        armed_d   = armed_q;
        arm_cnt_d = '0;
        if (!armed_q && db_q && sync2_q) begin
            if (arm_cnt_q == DB_W'(DB_CYCLES - 1)) armed_d   = 1'b1;
            else                                   arm_cnt_d = arm_cnt_q + DB_W'(1);
        end
    end

    always_comb begin : press_c
        press_cnt_d = '0;
        short_d     = 1'b0;
        long_d      = 1'b0;
        if (armed_q && !db_q) begin
            if (db_d) begin
                short_d = (press_cnt_q != PRESS_W'(LONG_CYCLES));
            end else if (press_cnt_q != PRESS_W'(LONG_CYCLES)) begin
                press_cnt_d = press_cnt_q + PRESS_W'(1);
                long_d      = (press_cnt_q == PRESS_W'(LONG_CYCLES - 1));
            end else begin
                press_cnt_d = press_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin : button_reg
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            db_q        <= 1'b1;
            db_cnt_q    <= '0;
            arm_cnt_q   <= '0;
            armed_q     <= 1'b0;
            press_cnt_q <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= ctrl.music_en;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            armed_q     <= armed_d;
            press_cnt_q <= press_cnt_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    // ---------------- sequencer ----------------
    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic                from_fetch_q, from_fetch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PITCH_W-1:0]  tone_q, tone_d;
    logic [PITCH_W-1:0]  pitch_q, pitch_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                playing_q, playing_d;
    logic                paused_q, paused_d;
    logic [LEN_W-1:0]    len_eff;

    assign len_eff = (note.len == '0) ? LEN_W'(1) : note.len;

    always_ff @(posedge clk) begin : state_reg
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Button events take priority over note expiry; long press overrides everything.
    always_comb begin : next_state_c
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (short_q) state_d = FETCH;
            FETCH: begin
                if (short_q) begin
                    state_d = PAUSE;
                end else if (phase_q) begin
                    if (note.pitch == END_MARK) state_d = ctrl.loop_en ? FETCH : IDLE;
                    else                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (short_q)                      state_d = PAUSE;
                else if (hold_q == HOLD_W'(1))    state_d = FETCH;
            end
            PAUSE: if (short_q) state_d = from_fetch_q ? FETCH : HOLD;
        endcase
        if (long_q) state_d = IDLE;
    end

    always_comb begin : output_c
        addr_d       = addr_q;
        tone_d       = tone_q;
        pitch_d      = pitch_q;
        hold_d       = hold_q;
        phase_d      = 1'b0;
        from_fetch_d = from_fetch_q;
        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                tone_d = '0;
            end
            FETCH: begin
                if (short_q) begin
                    from_fetch_d = 1'b1;
                    tone_d       = '0;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (note.pitch == END_MARK) begin
                    addr_d = '0;
                    if (!ctrl.loop_en) tone_d = '0;
                end else begin
                    hold_d  = HOLD_W'(len_eff) * HOLD_W'(BEAT_CYCLES);
                    tone_d  = note.pitch;
                    pitch_d = note.pitch;
                end
            end
            HOLD: begin
                if (short_q) begin
                    from_fetch_d = 1'b0;
                    tone_d       = '0;
                end else if (hold_q == HOLD_W'(1)) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            PAUSE: if (short_q) tone_d = pitch_q;
        endcase
        if (long_q) begin
            addr_d       = '0;
            tone_d       = '0;
            pitch_d      = '0;
            hold_d       = '0;
            from_fetch_d = 1'b0;
        end
        playing_d = (state_d == FETCH) || (state_d == HOLD);
        paused_d  = (state_d == PAUSE);
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (rst) begin
            phase_q      <= 1'b0;
            from_fetch_q <= 1'b0;
            addr_q       <= '0;
            tone_q       <= '0;
            pitch_q      <= '0;
            hold_q       <= '0;
            playing_q    <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            from_fetch_q <= from_fetch_d;
            addr_q       <= addr_d;
            tone_q       <= tone_d;
            pitch_q      <= pitch_d;
            hold_q       <= hold_d;
            playing_q    <= playing_d;
            paused_q     <= paused_d;
        end
    end

    assign ctrl.rom_addr  = addr_q;
    assign ctrl.tone_code = tone_q;
    assign ctrl.playing   = playing_q;
    assign ctrl.paused    = paused_q;
    assign ctrl.short_evt = short_q;
    assign ctrl.long_evt  = long_q;
endmodule

// File: tb/tb_music_ctrl.sv
// Directed bench for music_ctrl with DB_CYCLES=4, LONG_CYCLES=20, BEAT_CYCLES=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_music_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    music_ctrl_if bus ();

    logic [7:0] rom [64];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    music_ctrl #(
        .DB_CYCLES  (4),
        .LONG_CYCLES(20),
        .BEAT_CYCLES(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int short_cnt = 0;
    int long_cnt = 0;

    // Each pulse is counted at the rising edge that ends its cycle.
    always @(posedge clk) begin
        if (bus.short_evt === 1'b1) short_cnt <= short_cnt + 1;
        if (bus.long_evt === 1'b1)  long_cnt  <= long_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            0:       return int'(bus.tone_code);
            1:       return int'(bus.rom_addr);
            2:       return int'(bus.playing);
            3:       return int'(bus.paused);
            4:       return int'(bus.long_evt);
            default: return -1;
        endcase
    endfunction

    // Tick until output 'sel' equals val or the budget runs out; cyc = ticks taken.
    task automatic wait_for(input int sel, input int val, input int budget, output int cyc);
        cyc = 0;
        while (obs(sel) != val && cyc < budget) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic press(input int n_low);
        bus.music_en = 1'b0;
        tick(n_low);
        bus.music_en = 1'b1;
    endtask

    task automatic rom_fill(input logic [7:0] v);
        foreach (rom[i]) rom[i] = v;
    endtask

    int cyc;
    int s0, l0;
    int low_cnt;

    initial begin
        rst          = 1'b1;
        bus.music_en = 1'b0;
        bus.loop_en  = 1'b0;
        rom_fill(8'h1F);

        // Reset held 3 cycles with the button pressed
        tick(3);
        check("rst_tone",    obs(0), 0);
        check("rst_addr",    obs(1), 0);
        check("rst_playing", obs(2), 0);
        check("rst_paused",  obs(3), 0);
        check("rst_short",   int'(bus.short_evt), 0);
        check("rst_long",    obs(4), 0);
        rst = 1'b0;
        s0 = short_cnt; l0 = long_cnt;
        tick(30);
        check("held_after_rst_long",  long_cnt - l0, 0);
        check("held_after_rst_play",  obs(2), 0);
        bus.music_en = 1'b1;
        tick(15);
        check("held_release_short", short_cnt - s0, 0);
        check("held_release_long",  long_cnt - l0, 0);

        // Bounce shorter than the debounce window
        s0 = short_cnt; l0 = long_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.music_en = 1'b0; tick(2);
            bus.music_en = 1'b1; tick(2);
        end
        tick(12);
        check("bounce_short",   short_cnt - s0, 0);
        check("bounce_long",    long_cnt - l0, 0);
        check("bounce_playing", obs(2), 0);

        // Play {2,5},{1,7},end with loop off
        rom_fill(8'h1F);
        rom[0] = 8'h45;
        rom[1] = 8'h27;
        s0 = short_cnt; l0 = long_cnt;
        press(10);
        wait_for(0, 5, 30, cyc);
        check("play_tone5",       obs(0), 5);
        check("play_start_lat",   cyc, 9);
        check("play_playing",     obs(2), 1);
        wait_for(1, 1, 40, cyc);
        check("note5_cycles",     cyc, 16);
        check("note5_tone_fetch", obs(0), 5);
        wait_for(0, 7, 10, cyc);
        check("fetch_cycles",     cyc, 2);
        wait_for(1, 2, 20, cyc);
        check("note7_cycles",     cyc, 8);
        wait_for(2, 0, 10, cyc);
        check("end_to_idle",      cyc, 2);
        check("end_tone",         obs(0), 0);
        check("end_addr",         obs(1), 0);
        check("play_short_once",  short_cnt - s0, 1);
        check("play_no_long",     long_cnt - l0, 0);

        // Pause with 5 cycles left of a 32-cycle note, then resume
        rom_fill(8'h1F);
        rom[0] = 8'h84;
        rom[1] = 8'h26;
        press(10);
        wait_for(0, 4, 30, cyc);
        check("pz_tone4", obs(0), 4);
        tick(11);
        bus.music_en = 1'b0;
        tick(10);
        bus.music_en = 1'b1;
        wait_for(3, 1, 20, cyc);
        check("pz_latency",  cyc, 7);
        check("pz_tone",     obs(0), 0);
        check("pz_playing",  obs(2), 0);
        tick(8);
        check("pz_addr_frozen", obs(1), 0);
        check("pz_still",       obs(3), 1);
        press(10);
        wait_for(0, 4, 20, cyc);
        check("resume_latency", cyc, 7);
        check("resume_paused",  obs(3), 0);
        wait_for(1, 1, 40, cyc);
        check("resume_hold_left", cyc, 5);
        wait_for(2, 0, 40, cyc);
        check("pz_song_end", cyc, 12);

        // Long press during a 56-cycle note
        rom_fill(8'h1F);
        rom[0] = 8'hE9;
        press(10);
        wait_for(0, 9, 30, cyc);
        check("lp_tone9", obs(0), 9);
        s0 = short_cnt; l0 = long_cnt;
        bus.music_en = 1'b0;
        wait_for(4, 1, 40, cyc);
        check("lp_latency", cyc, 26);
        tick(40 - cyc);
        check("lp_once",    long_cnt - l0, 1);
        check("lp_playing", obs(2), 0);
        check("lp_addr",    obs(1), 0);
        check("lp_tone",    obs(0), 0);
        bus.music_en = 1'b1;
        tick(15);
        check("lp_release_short", short_cnt - s0, 0);
        check("lp_release_long",  long_cnt - l0, 1);

        // Loop at an end marker on address 2
        rom_fill(8'h1F);
        rom[0] = 8'h23;
        rom[1] = 8'h29;
        bus.loop_en = 1'b1;
        press(10);
        wait_for(0, 3, 30, cyc);
        check("loop_tone3", obs(0), 3);
        wait_for(1, 2, 40, cyc);
        check("loop_to_addr2", cyc, 18);
        wait_for(1, 0, 10, cyc);
        check("loop_addr_back", cyc, 2);
        check("loop_playing",   obs(2), 1);
        wait_for(0, 3, 10, cyc);
        check("loop_refetch", cyc, 2);
        low_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (bus.playing !== 1'b1) low_cnt++;
        end
        check("loop_play_gaps", low_cnt, 0);
        bus.music_en = 1'b0;
        wait_for(2, 0, 40, cyc);
        check("loop_long_stop", cyc, 27);
        bus.music_en = 1'b1;
        bus.loop_en  = 1'b0;
        tick(15);

        // Address wrap 63 -> 0 without an end marker
        rom_fill(8'h22);
        press(10);
        wait_for(1, 63, 1000, cyc);
        check("wrap_reach63", obs(1), 63);
        wait_for(1, 0, 20, cyc);
        check("wrap_to0",      cyc, 10);
        check("wrap_playing",  obs(2), 1);

        // Reset mid-note aborts silently
        s0 = short_cnt; l0 = long_cnt;
        rst = 1'b1;
        tick(2);
        check("midrst_tone",    obs(0), 0);
        check("midrst_playing", obs(2), 0);
        rst = 1'b0;
        tick(12);
        check("midrst_events",  (short_cnt - s0) + (long_cnt - l0), 0);
        check("midrst_addr",    obs(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
